fast_com_decoder: RTL

FAST_COM_DECODER -- requirements
Module: fast_com_decoder

---
 rtl/fast_com_decoder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fast_com_decoder.sv
//------------------------------------------------------------------------------
// fast_com_decoder
//
// Purpose:
//   Recovers byte alignment on a 320 Mb/s fast-command serial stream and
//   decodes the aligned bytes into one-hot command strobes. Alignment is found
//   by hunting for the IDLE pattern (0xF0) at any bit position. It is then
//   confirmed over LOCK_COUNT consecutive byte boundaries. Lock is dropped
//   after UNLOCK_ERR consecutive illegal bytes.
//
// Parameters:
//   LOCK_COUNT  consecutive aligned IDLE bytes needed to lock   (2..15)
//   UNLOCK_ERR  consecutive illegal bytes that drop lock         (1..15)
//
// Ports:
//   clk320         in   320 MHz bit clock, rising edge
//   rstn           in   asynchronous active-low reset
//   fastComSerial  in   serial stream, MSB of each byte first
//   aligned        out  high while locked
//   byteValid      out  one-cycle strobe per decoded byte
//   fastComByte    out  last captured aligned byte, held between strobes
//   cmdPulse       out  one-hot command strobe, qualified by byteValid
//   cmdErr         out  one-cycle strobe for an aligned illegal byte
//   errCount       out  saturating count of illegal bytes seen while locked
//
// Configuration:
//   FC_DECODER_ERRCNT_EN  when defined, errCount counts illegal locked bytes
//                         and saturates at 255. It is cleared only by reset.
//                         When undefined, errCount is tied to zero.
//------------------------------------------------------------------------------
module fast_com_decoder #(
  parameter int LOCK_COUNT = 4,
  parameter int UNLOCK_ERR = 4
) (
  input  logic       clk320,
  input  logic       rstn,
  input  logic       fastComSerial,
  output logic       aligned,
  output logic       byteValid,
  output logic [7:0] fastComByte,
  output logic [9:0] cmdPulse,
  output logic       cmdErr,
  output logic [7:0] errCount
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [7:0] IDLE_CODE  = 8'hF0;
  localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_COUNT);
  localparam logic [3:0] ERR_LIMIT  = 4'(UNLOCK_ERR);

  // Legal codes, entry n drives cmdPulse[n].
  localparam logic [79:0] CODE_TABLE = {
    8'hAA, 8'hA5, 8'h99, 8'h96, 8'h69,
    8'h66, 8'h55, 8'h5A, 8'h33, 8'hF0
  };

  logic [1:0] r_state;
  logic [7:0] r_shreg;
  logic [2:0] r_phase;
  logic [3:0] r_good_cnt;
  logic [3:0] r_err_run;
  logic       r_byte_valid;
  logic [7:0] r_byte;
  logic [9:0] r_cmd_pulse;
  logic       r_cmd_err;

  logic [9:0] w_onehot;
  logic       w_legal;
  logic       w_is_idle;
  logic       w_boundary;
  logic [3:0] w_good_inc;
  logic [3:0] w_err_inc;

  for (genvar gi = 0; gi < 10; gi++) begin : g_decode
    assign w_onehot[gi] = (r_shreg == CODE_TABLE[gi*8 +: 8]);
  end

  assign w_legal    = |w_onehot;
  assign w_is_idle  = (r_shreg == IDLE_CODE);
  // Phase is 0 on the cycle after the alignment match, so phase 7 is the
  // cycle in which the shift register holds a complete byte.
  assign w_boundary = (r_phase == 3'd7);
  assign w_good_inc = r_good_cnt + 4'd1;
  assign w_err_inc  = r_err_run + 4'd1;

  always_ff @(posedge clk320 or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_SEARCH;
      r_shreg      <= 8'h00;
      r_phase      <= 3'd0;
      r_good_cnt   <= 4'd0;
      r_err_run    <= 4'd0;
      r_byte_valid <= 1'b0;
      r_byte       <= 8'h00;
      r_cmd_pulse  <= 10'd0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_shreg      <= {r_shreg[6:0], fastComSerial};
      r_phase      <= r_phase + 3'd1;
      r_byte_valid <= 1'b0;
      r_cmd_pulse  <= 10'd0;
      r_cmd_err    <= 1'b0;

      case (r_state)
        ST_SEARCH: begin
          // A match restarts the phase even if it lands on a boundary.
          if (w_is_idle) begin
            r_phase    <= 3'd0;
            r_good_cnt <= 4'd1;
            r_state    <= ST_CONFIRM;
          end
        end

        ST_CONFIRM: begin
          if (w_boundary) begin
            if (w_is_idle) begin
              r_good_cnt <= w_good_inc;
              if (w_good_inc == LOCK_LIMIT) begin
                r_state   <= ST_LOCKED;
                r_err_run <= 4'd0;
              end
            end else begin
              r_good_cnt <= 4'd0;
              r_state    <= ST_SEARCH;
            end
          end
        end

        ST_LOCKED: begin
          if (w_boundary) begin
            r_byte_valid <= 1'b1;
            r_byte       <= r_shreg;
            r_cmd_pulse  <= w_onehot;
            r_cmd_err    <= ~w_legal;
            if (w_legal) begin
              r_err_run <= 4'd0;
            end else if (w_err_inc == ERR_LIMIT) begin
              // The offending byte is still reported; lock drops on the
              // same edge that launches its strobe.
              r_err_run  <= 4'd0;
              r_good_cnt <= 4'd0;
              r_state    <= ST_SEARCH;
            end else begin
              r_err_run <= w_err_inc;
            end
          end
        end

        default: begin
          r_state <= ST_SEARCH;
        end
      endcase
    end
  end

`ifdef FC_DECODER_ERRCNT_EN
  logic [7:0] r_err_count;
  logic       w_err_hit;

  assign w_err_hit = (r_state == ST_LOCKED) && w_boundary && !w_legal;

  always_ff @(posedge clk320 or negedge rstn) begin
    if (!rstn) begin
      r_err_count <= 8'd0;
    end else if (w_err_hit && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign errCount = r_err_count;
`else
  assign errCount = 8'd0;
`endif

  assign aligned     = (r_state == ST_LOCKED);
  assign byteValid   = r_byte_valid;
  assign fastComByte = r_byte;
  assign cmdPulse    = r_cmd_pulse;
  assign cmdErr      = r_cmd_err;

endmodule
